// File: rtl/compressed_adder_seq.sv
`default_nettype none
// ============================================================================
// Module : compressed_adder_seq
// Streaming controller for one 20-bit compressed_adder slice; chains carry
// across beats (LS beat first). Option macro COMPRESSED_ADDER_SEQ_SUB_EN adds
// the s_sub port for per-packet A - B.
// Rev    : 1.0
// ============================================================================
module compressed_adder_seq #(
  parameter int W         = 20,
  parameter int MAX_BEATS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_a,
  input  logic [W-1:0]   s_b,
  input  logic           s_last,
`ifdef COMPRESSED_ADDER_SEQ_SUB_EN
  input  logic           s_sub,
`endif
  output logic           m_valid,
  input  logic           m_ready,
  output logic [W-1:0]   m_sum,
  output logic           m_last,
  output logic           m_cout,
  output logic           m_err,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic [W/2-1:0] add_gc,
  output logic           add_cin,
  input  logic [W-1:0]   add_sum
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]     r_state, w_state_nxt;
  logic           r_s_valid, r_s_last, r_o_valid, r_carry;
  logic [W-1:0]   r_s_a, r_s_b;
  logic [CNT_W-1:0] r_beat_cnt;
  logic           w_xfer, w_accept, w_forced, w_end, w_first;
  logic           w_sub, w_sub_in;
  logic [W/2-1:0] w_g, w_p;

  assign w_xfer   = r_s_valid && (!r_o_valid || m_ready);
  assign s_ready  = !r_s_valid || w_xfer;
  assign w_accept = s_valid && s_ready;
  assign w_forced = !r_s_last && (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign w_end    = r_s_last || w_forced;
  assign m_valid  = r_o_valid;

`ifdef COMPRESSED_ADDER_SEQ_SUB_EN
  logic r_sub;
  assign w_sub_in = s_sub;
  assign w_sub    = r_sub;
  // Mode is latched with a packet's first beat and applies to every beat in S.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_sub <= 1'b0;
    else if (w_accept && w_first) r_sub <= s_sub;
  end
`else
  assign w_sub_in = 1'b0;
  assign w_sub    = 1'b0;
`endif

  assign add_a   = r_s_a;
  assign add_b   = w_sub ? ~r_s_b : r_s_b;
  assign add_cin = r_carry;

  for (genvar gi = 0; gi < W/2; gi++) begin : g_grp
    assign w_g[gi] = (add_a[2*gi+1] & add_b[2*gi+1]) |
                     ((add_a[2*gi+1] ^ add_b[2*gi+1]) & add_a[2*gi] & add_b[2*gi]);
    assign w_p[gi] = (add_a[2*gi+1] ^ add_b[2*gi+1]) & (add_a[2*gi] ^ add_b[2*gi]);
  end

  always_comb begin
    logic v_c;
    v_c    = r_carry;
    add_gc = '0;
    for (int i = 0; i < W/2; i++) begin
      v_c       = w_g[i] | (w_p[i] & v_c);
      add_gc[i] = v_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer && w_end) w_state_nxt = S_IDLE;
    if (w_accept)        w_state_nxt = S_BUSY;
  end

  // A beat opens a packet when nothing is in flight or its predecessor closes now.
  always_comb begin
    w_first = (r_state == S_IDLE) || (w_xfer && w_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_valid <= 1'b0;
      r_s_last  <= 1'b0;
      r_s_a     <= '0;
      r_s_b     <= '0;
    end else if (w_accept) begin
      r_s_valid <= 1'b1;
      r_s_last  <= s_last;
      r_s_a     <= s_a;
      r_s_b     <= s_b;
    end else if (w_xfer) begin
      r_s_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_carry <= 1'b0;
    else if (w_accept && w_first) r_carry <= w_sub_in;
    else if (w_xfer)              r_carry <= w_end ? w_sub : add_gc[W/2-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_beat_cnt <= '0;
    else if (w_xfer) r_beat_cnt <= w_end ? '0 : r_beat_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o_valid <= 1'b0;
      m_sum     <= '0;
      m_last    <= 1'b0;
      m_cout    <= 1'b0;
      m_err     <= 1'b0;
    end else if (w_xfer) begin
      r_o_valid <= 1'b1;
      m_sum     <= add_sum;
      m_last    <= w_end;
      m_cout    <= add_gc[W/2-1];
      m_err     <= w_forced;
    end else if (m_ready) begin
      r_o_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
